// File: rtl/fp_div_normalizer_pkg.sv
// Shared types and constants for the divider normalize-and-pack stage.
// Field offsets describe the packed IEEE-754 single-precision result word.
package fp_div_pkg;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 24;
  localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'hFF;

  localparam int RES_W        = 32;
  localparam int RES_SIGN_BIT = 31;
  localparam int RES_EXP_LSB  = 23;
  localparam int RES_FRAC_LSB = 0;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
endpackage

// File: rtl/fp_div_normalizer_if.sv
// Operand/result handshake bundle; names follow the normalizer's point of view.
interface fp_div_normalizer_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 24
) ();
  logic             valid_i;
  logic             ready_o;
  logic             s_i;
  logic [EXP_W-1:0] e_i;
  logic [MAN_W-1:0] q_i;
  logic             valid_o;
  logic             ready_i;
  logic [31:0]      result_o;
  logic             uf_o;
  logic             of_o;

  modport slave (
    input  valid_i, s_i, e_i, q_i, ready_i,
    output ready_o, valid_o, result_o, uf_o, of_o
  );

  modport master (
    output valid_i, s_i, e_i, q_i, ready_i,
    input  ready_o, valid_o, result_o, uf_o, of_o
  );
endinterface

// File: rtl/fp_pack_single.sv
// Combinational packer: builds {sign, exp, frac}, or a signed zero / signed infinity.
module fp_pack_single
  import fp_div_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic             s,
  input  logic [EXP_W-1:0] e,
  input  logic [MAN_W-2:0] frac,
  input  logic             zero_sel,
  input  logic             inf_sel,
  output logic [RES_W-1:0] word
);
  always_comb begin
    word               = '0;
    word[RES_SIGN_BIT] = s;
    if (inf_sel) begin
      word[RES_EXP_LSB +: EXP_W] = {EXP_W{1'b1}};
    end else if (!zero_sel) begin
      word[RES_EXP_LSB +: EXP_W]   = e;
      word[RES_FRAC_LSB +: MAN_W-1] = frac;
    end
  end
endmodule

// File: rtl/fp_div_normalizer.sv
// Normalizes the divider quotient one bit per cycle, then packs a single-precision
// result with underflow/overflow flags. One operation in flight at a time.
module fp_div_normalizer
  import fp_div_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  fp_div_normalizer_if.slave  io
);
  localparam logic [EXP_W-1:0] E_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             s_q, s_d;
  logic [EXP_W-1:0] e_q, e_d;
  logic [MAN_W-1:0] q_q, q_d;
  logic [RES_W-1:0] result_q, result_d;
  logic             uf_q, uf_d, of_q, of_d;

  logic             q_zero, e_max, e_zero, norm;
  logic             zero_sel, inf_sel, finish;
  logic [RES_W-1:0] packed_word;

  // Priority: zero quotient, saturated exponent, normalized, exponent exhausted.
  always_comb begin
    q_zero   = (q_q == '0);
    e_max    = (e_q == {EXP_W{1'b1}});
    e_zero   = (e_q == '0);
    norm     = q_q[MAN_W-1];
    inf_sel  = !q_zero && e_max;
    zero_sel = q_zero || (!e_max && !norm && e_zero);
    finish   = q_zero || e_max || norm || e_zero;
  end

  fp_pack_single #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_pack (
    .s        (s_q),
    .e        (e_q),
    .frac     (q_q[MAN_W-2:0]),
    .zero_sel (zero_sel),
    .inf_sel  (inf_sel),
    .word     (packed_word)
  );

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    e_d      = e_q;
    q_d      = q_q;
    result_d = result_q;
    uf_d     = uf_q;
    of_d     = of_q;
    case (state_q)
      IDLE: begin
        if (io.valid_i) begin
          state_d = SHIFT;
          s_d     = io.s_i;
          e_d     = io.e_i;
          q_d     = io.q_i;
        end
      end
      SHIFT: begin
        if (finish) begin
          state_d  = DONE;
          result_d = packed_word;
          of_d     = inf_sel;
          uf_d     = !q_zero && !e_max && !norm;
        end else begin
          q_d = q_q << 1;
          e_d = e_q - E_ONE;
        end
      end
      DONE: begin
        if (io.ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      s_q      <= 1'b0;
      e_q      <= '0;
      q_q      <= '0;
      result_q <= '0;
      uf_q     <= 1'b0;
      of_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      e_q      <= e_d;
      q_q      <= q_d;
      result_q <= result_d;
      uf_q     <= uf_d;
      of_q     <= of_d;
    end
  end

  assign io.ready_o  = (state_q == IDLE);
  assign io.valid_o  = (state_q == DONE);
  assign io.result_o = result_q;
  assign io.uf_o     = uf_q;
  assign io.of_o     = of_q;
endmodule
